peak_frame_buffer: RTL and testbench

PEAK_FRAME_BUFFER -- requirements
Module: peak_frame_buffer

---
 rtl/peak_frame_buffer.sv | 134 +++++++++++++
 tb/tb_peak_frame_buffer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/peak_frame_buffer.sv
// Circular buffer of window peaks that streams one whole frame, oldest to newest,
// on request. Peaks arriving mid-stream are parked in a one-deep pending slot.
module peak_frame_buffer #(
  parameter int FRAME_LEN = 8,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_start,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  output logic              o_frame_full,
  output logic              o_busy,
  output logic              o_dropped
);

  localparam int PTR_W = $clog2(FRAME_LEN);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_LEN);
  localparam logic [PTR_W-1:0] LAST_BEAT = PTR_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              dropped_q, dropped_d;

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] mem [FRAME_LEN];

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    beat_d       = beat_q;
    fill_d       = fill_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    dropped_d    = dropped_q;
    wr_en        = 1'b0;
    wr_data      = i_data;

    case (state_q)
      IDLE: begin
        // A parked peak drains first; a fresh peak this cycle takes its slot.
        if (pend_valid_q) begin
          wr_en        = 1'b1;
          wr_data      = pend_q;
          pend_valid_d = i_valid;
          if (i_valid) pend_d = i_data;
        end else if (i_valid) begin
          wr_en = 1'b1;
        end

        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          if (fill_q != FULL_CNT) fill_d = fill_q + CNT_W'(1);
        end

        // Post-write pointer makes a same-cycle peak the newest beat of the frame.
        if (i_start && !pend_valid_q && (fill_d == FULL_CNT)) begin
          state_d  = STREAM;
          rd_ptr_d = wr_ptr_d;
          beat_d   = '0;
        end
      end

      STREAM: begin
        if (i_valid) begin
          if (!pend_valid_q) begin
            pend_d       = i_data;
            pend_valid_d = 1'b1;
          end else begin
            dropped_d = 1'b1;
          end
        end

        if (i_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          beat_d   = beat_q + PTR_W'(1);
          if (beat_q == LAST_BEAT) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      beat_q       <= '0;
      fill_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      beat_q       <= beat_d;
      fill_q       <= fill_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      dropped_q    <= dropped_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; fill count gates any use of stale data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign o_busy       = (state_q == STREAM);
  assign o_valid      = o_busy;
  assign o_last       = o_busy && (beat_q == LAST_BEAT);
  assign o_data       = o_busy ? mem[rd_ptr_q] : '0;
  assign o_frame_full = (fill_q == FULL_CNT);
  assign o_dropped    = dropped_q;

endmodule

// File: tb/tb_peak_frame_buffer.sv
// Directed bench for peak_frame_buffer: inputs change and outputs are sampled on the
// falling clock edge, away from the rising edge where the DUT updates.
module tb_peak_frame_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_data;
  logic       i_valid, i_start, i_ready;
  logic [7:0] o_data;
  logic       o_valid, o_last, o_frame_full, o_busy, o_dropped;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_frame [8];

  peak_frame_buffer #(.FRAME_LEN(8), .DATA_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_start      (i_start),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_last       (o_last),
    .o_frame_full (o_frame_full),
    .o_busy       (o_busy),
    .o_dropped    (o_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] v);
    i_valid = 1'b1;
    i_data  = v;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic start_frame();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".o_valid"}, o_valid, 0);
    check({tag, ".o_busy"},  o_busy,  0);
    check({tag, ".o_last"},  o_last,  0);
    check({tag, ".o_data"},  o_data,  0);
  endtask

  // Called at the first falling edge after i_start was accepted. stall selects the
  // ready pattern 1,0,0,1,0,0...; inject pulses 0xAA then 0xBB during the stream.
  task automatic expect_frame(input string tag, input bit stall, input bit inject);
    int  k   = 0;
    int  cyc = 0;
    bit  rdy;
    while (k < 8 && cyc < 64) begin
      check({tag, ".valid"}, o_valid, 1);
      check({tag, ".busy"},  o_busy,  1);
      check({tag, ".data"},  o_data,  exp_frame[k]);
      check({tag, ".last"},  o_last,  (k == 7));
      check({tag, ".full"},  o_frame_full, 1);
      rdy     = stall ? (cyc % 3 == 0) : 1'b1;
      i_ready = rdy;
      i_valid = inject && (cyc == 1 || cyc == 2);
      i_data  = (cyc == 1) ? 8'hAA : 8'hBB;
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    i_ready = 1'b0;
    i_valid = 1'b0;
    check({tag, ".beats"}, k, 8);
    check({tag, ".end_valid"}, o_valid, 0);
    check({tag, ".end_busy"},  o_busy,  0);
  endtask

  initial begin
    reset   = 1'b0;
    i_data  = '0;
    i_valid = 1'b0;
    i_start = 1'b0;
    i_ready = 1'b0;
    #1;
    check_idle_outputs("reset");
    check("reset.full",    o_frame_full, 0);
    check("reset.dropped", o_dropped,    0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Start with a partial frame is ignored.
    for (int i = 1; i <= 5; i++) push(8'(10 * i));
    start_frame();
    check_idle_outputs("partial_start");
    check("partial.full", o_frame_full, 0);
    push(8'd60);
    push(8'd70);
    check("seven.full", o_frame_full, 0);
    push(8'd80);
    check("eight.full", o_frame_full, 1);

    // Basic frame, ready always high.
    start_frame();
    for (int i = 0; i < 8; i++) exp_frame[i] = 8'(10 * (i + 1));
    expect_frame("basic", 1'b0, 1'b0);
    check("basic.full_after", o_frame_full, 1);

    // Wrap-around: 11 peaks, oldest three overwritten.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst2.full", o_frame_full, 0);
    for (int i = 1; i <= 11; i++) push(8'(i));
    start_frame();
    for (int i = 0; i < 8; i++) exp_frame[i] = 8'(i + 4);
    expect_frame("wrap", 1'b0, 1'b0);

    // Same frame again with back-pressure stalls.
    start_frame();
    expect_frame("stall", 1'b1, 1'b0);

    // Peaks during stream: first parked, second dropped.
    start_frame();
    check("inject.pre_dropped", o_dropped, 0);
    expect_frame("inject", 1'b0, 1'b1);
    check("inject.dropped", o_dropped, 1);
    start_frame();  // pending still parked here, so this request is ignored
    check("pending_start.busy", o_busy, 0);
    start_frame();
    exp_frame = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'hAA};
    expect_frame("after_inject", 1'b0, 1'b0);
    check("sticky.dropped", o_dropped, 1);

    // Reset after three beats aborts the frame.
    start_frame();
    i_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("abort.mid_busy", o_busy, 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("abort");
    check("abort.full",    o_frame_full, 0);
    check("abort.dropped", o_dropped,    0);
    i_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 1; i <= 7; i++) push(8'(100 + i));
    start_frame();
    check("refill7.busy", o_busy, 0);
    check("refill7.full", o_frame_full, 0);
    // Eighth peak and start in the same cycle: the new peak is the last beat.
    i_valid = 1'b1;
    i_data  = 8'd108;
    i_start = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    i_start = 1'b0;
    for (int i = 0; i < 8; i++) exp_frame[i] = 8'(101 + i);
    expect_frame("refill", 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
